// File: rtl/exp_unit_rr_arbiter_if.sv
// Bundle between the exp-unit arbiter, its requesters and the shared exp unit.
// master: arbiter side; slave: requester array plus exp unit side.
`ifndef FRACWIDTH
`define FRACWIDTH 16
`endif

interface exp_unit_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `FRACWIDTH
);
  logic [NUM_REQ-1:0]        iReqValid;
  logic [NUM_REQ*DATA_W-1:0] iReqData;
  logic [NUM_REQ-1:0]        oReqAck;
  logic [NUM_REQ*DATA_W-1:0] oRspData;
  logic [NUM_REQ-1:0]        oRspValid;
  logic [NUM_REQ-1:0]        oRspErr;
  logic [NUM_REQ-1:0]        iRspRead;
  logic [DATA_W-1:0]         oExpData;
  logic                      oExpDataValid;
  logic [DATA_W-1:0]         iExpData;
  logic                      iExpDataValid;
  logic                      oExpDataRead;
  logic                      oBusy;
  logic                      oTimeout;

  modport master (
    input  iReqValid,
    input  iReqData,
    input  iRspRead,
    input  iExpData,
    input  iExpDataValid,
    output oReqAck,
    output oRspData,
    output oRspValid,
    output oRspErr,
    output oExpData,
    output oExpDataValid,
    output oExpDataRead,
    output oBusy,
    output oTimeout
  );

  modport slave (
    output iReqValid,
    output iReqData,
    output iRspRead,
    output iExpData,
    output iExpDataValid,
    input  oReqAck,
    input  oRspData,
    input  oRspValid,
    input  oRspErr,
    input  oExpData,
    input  oExpDataValid,
    input  oExpDataRead,
    input  oBusy,
    input  oTimeout
  );
endinterface

// File: rtl/exp_unit_rr_arbiter.sv
// Round-robin sequencer sharing one non-pipelined exp unit among NUM_REQ
// requesters. Ports: clk, rst_n (sync, active-low), bus (master modport).
`ifndef FRACWIDTH
`define FRACWIDTH 16
`endif

module exp_unit_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `FRACWIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exp_unit_rr_arbiter_if.master bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             grant_idx;
  logic [PW-1:0]             pick;
  logic                      found;
  logic [NUM_REQ-1:0]        elig;
  logic [DATA_W-1:0]         op_reg;
  logic [CW-1:0]             cnt;
  logic [NUM_REQ*DATA_W-1:0] rsp_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_err;
  logic                      timeout_q;
  logic                      hit;
  logic                      expire;
  logic                      grant;

  // Index arithmetic modulo NUM_REQ for sums below 2*NUM_REQ.
  function automatic logic [PW-1:0] wrap(input int v);
    if (v >= NUM_REQ) begin
      return PW'(v - NUM_REQ);
    end
    return PW'(v);
  endfunction

  // A requester still holding an unread result cannot be granted.
  assign elig = bus.iReqValid & ~rsp_valid;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        pick  = wrap(int'(rr_ptr) + k);
      end
    end
  end

  assign grant  = (state == S_IDLE) && found;
  assign hit    = (state == S_WAIT) && bus.iExpDataValid;
  // A result arriving in the last WAIT cycle wins over the watchdog.
  assign expire = (state == S_WAIT) && !bus.iExpDataValid
                  && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (hit || expire) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.oReqAck       = '0;
    bus.oExpDataValid = 1'b0;
    bus.oExpDataRead  = 1'b0;
    bus.oBusy         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          bus.oReqAck[pick] = 1'b1;
        end
      end
      S_ISSUE: begin
        bus.oExpDataValid = 1'b1;
        bus.oBusy         = 1'b1;
      end
      S_WAIT: begin
        bus.oExpDataRead = bus.iExpDataValid;
        bus.oBusy        = 1'b1;
      end
      default: begin
        bus.oBusy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      op_reg    <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant) begin
        op_reg    <= bus.iReqData[pick*DATA_W +: DATA_W];
        grant_idx <= pick;
        rr_ptr    <= wrap(int'(pick) + 1);
      end
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Completion for the granted slot has priority over a read; the two
  // cannot collide because a slot is only granted while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((hit || expire) && (grant_idx == PW'(i))) begin
          rsp_valid[i] <= 1'b1;
          rsp_err[i]   <= expire;
          rsp_data[i*DATA_W +: DATA_W] <= hit ? bus.iExpData : '0;
        end else if (bus.iRspRead[i] && rsp_valid[i]) begin
          rsp_valid[i] <= 1'b0;
          rsp_err[i]   <= 1'b0;
        end
      end
    end
  end

  assign bus.oExpData  = op_reg;
  assign bus.oRspData  = rsp_data;
  assign bus.oRspValid = rsp_valid;
  assign bus.oRspErr   = rsp_err;
  assign bus.oTimeout  = timeout_q;

endmodule

// File: doc/exp_unit_rr_arbiter.md
# exp_unit_rr_arbiter

Round-robin arbiter and sequencer that shares one non-pipelined exponential unit (exp_taylor_01_npp interface: iData/iDataValid in, oData/oDataValid/oDataRead out) between NUM_REQ neuron requesters. It accepts one request at a time, issues it to the unit, waits for the result and parks the result in a per-requester response register. A watchdog flags a unit that never answers. It sits between the neuron array and the single shared exp instance in the configurable neuron datapath.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- DATA_W, default `FRACWIDTH: operand and result width.
- TIMEOUT, default 64: maximum cycles spent in WAIT before the watchdog fires, at least 2.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- iReqValid  in  NUM_REQ  per-requester request.
- iReqData  in  NUM_REQ*DATA_W  packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- oReqAck  out  NUM_REQ  one-hot, single-cycle accept pulse.
- oRspData  out  NUM_REQ*DATA_W  packed per-requester result registers.
- oRspValid  out  NUM_REQ  result held for requester i.
- oRspErr  out  NUM_REQ  the held result is a timeout (oRspData is 0).
- iRspRead  in  NUM_REQ  requester i consumes its result.
- oExpData  out  DATA_W  operand to the unit's iData.
- oExpDataValid  out  1  single-cycle issue strobe to the unit's iDataValid.
- iExpData  in  DATA_W  from the unit's oData.
- iExpDataValid  in  1  from the unit's oDataValid.
- oExpDataRead  out  1  to the unit's oDataRead.
- oBusy  out  1  state is not IDLE.
- oTimeout  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **Eligibility:** requester i is eligible when iReqValid[i]=1 and the registered oRspValid[i]=0. A requester holding an unread result is never granted.
- **IDLE:**
  - Search from rrPtr upward, wrapping mod NUM_REQ; the first eligible index is g.
  - oReqAck[g]=1 combinationally in that cycle.
  - At the clock edge: latch iReqData slice g into opReg, store g in grantIdx, set rrPtr <= (g+1) mod NUM_REQ, and go to ISSUE.
  - With no eligible requester: stay in IDLE and hold rrPtr.
- **ISSUE:**
  - oExpDataValid=1 and oExpData=opReg for exactly this cycle.
  - Clear the watchdog counter; go to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - If iExpDataValid=1: oExpDataRead=1 combinationally in this cycle, oRspData[grantIdx] <= iExpData, oRspValid[grantIdx] <= 1, oRspErr[grantIdx] <= 0, then go to IDLE.
  - Else if the counter reaches TIMEOUT-1: oTimeout <= 1, oRspData[grantIdx] <= 0, oRspValid[grantIdx] <= 1, oRspErr[grantIdx] <= 1, then go to IDLE.
  - Result arrival wins over a timeout in the same cycle.
- **Response registers:** iRspRead[i] with oRspValid[i]=1 clears oRspValid[i] and oRspErr[i] at the edge. iRspRead with no held result is ignored. Data registers keep their last value.
- oExpData is driven with opReg at all times. oExpDataValid and oExpDataRead are 0 outside ISSUE and WAIT respectively.
- **Reset** (rst_n=0 at an edge), including mid-transaction:
  - state IDLE, rrPtr=0, grantIdx=0, opReg=0, counter=0.
  - All oRspData, oRspValid and oRspErr are 0; oTimeout=0.
  - All combinational outputs are 0. No result is delivered for an aborted transaction.

## Timing
- **Fastest path:** ack in cycle t (IDLE), issue strobe in t+1, WAIT from t+2.
- A unit result valid in cycle w (w ≥ t+2) is read in w and appears on oRspValid from w+1.
- **Timeout:** with no answer, WAIT occupies cycles t+2..t+TIMEOUT+1; the error response is visible from t+TIMEOUT+2.
- **Back-to-back:** the next ack can occur in w+1, when the FSM is back in IDLE.
- **Read and re-request:** iRspRead[i] in cycle r lets requester i be granted no earlier than r+1.
- Requesters hold iReqValid and iReqData stable until ack. Ack consumes the request; dropping iReqValid after ack is the requester's responsibility. A valid still high after ack is a new request.

## Test plan
- **Single request:** NUM_REQ=4, iReqValid=4'b0010 with data 128; the unit returns 131 four cycles after the issue strobe.
  - Required: oReqAck=4'b0010 in cycle t and one oExpDataValid pulse carrying 128.
  - oRspValid[1]=1 with oRspData slice 1 = 131 and oRspErr[1]=0; nothing changes until iRspRead[1].
- **Fairness:** all four requesters valid continuously, each reading its result immediately.
  - Required: grant order 0,1,2,3,0,1 and no requester granted twice within any window of 4 grants.
- **Blocked requester:** requester 0 holds an unread result and re-requests alongside requester 2.
  - Required: 2 is granted and 0 is skipped.
  - After iRspRead[0], 0 is granted next, at the earliest the following cycle.
- **Watchdog:** TIMEOUT=8 and the unit never asserts iExpDataValid.
  - Required: oTimeout=1 and oRspErr[g]=1 with data 0, visible at ack+10.
  - The FSM returns to IDLE and the next request is served normally; oTimeout stays 1.
- **Simultaneous result and timeout:** the result arrives exactly at counter TIMEOUT-1.
  - Required: the real data is delivered, oRspErr=0 and oTimeout stays 0.
- **Reset mid-operation:** rst_n=0 for one edge while in WAIT with oRspValid=4'b1001.
  - Required: all outputs read 0 and the state is IDLE.
  - The next request goes to the lowest-indexed eligible requester, since rrPtr=0.
